// File: rtl/traffic_light_nway.sv
// rtl/traffic_light_nway.sv - N-way traffic light controller with minimum/maximum green and flashing-yellow mode
//
// Purpose: rotates right of way among N_DIR approaches. A direction keeps
// green while nobody else waits. The green is cut short once the minimum
// time has passed and its own sensor has gone quiet, or once the maximum
// time is reached. Each green ends with yellow and then an all-red
// clearance. flash_en overrides everything except rst and blinks all
// yellows.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   sensor   - per-direction vehicle presence
//   flash_en - request flashing-yellow mode
//   red      - per-direction red lamp
//   yellow   - per-direction yellow lamp
//   green    - per-direction green lamp
//   active   - direction that owns the current phase
//   phase    - 0 GREEN, 1 YELLOW, 2 ALLRED, 3 FLASH
module traffic_light_nway #(
  parameter int N_DIR      = 4,
  parameter int GREEN_MIN  = 8,
  parameter int GREEN_MAX  = 32,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 1,
  parameter int FLASH_HALF = 4,
  localparam int AW        = (N_DIR > 2) ? $clog2(N_DIR) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DIR-1:0] sensor,
  input  logic             flash_en,
  output logic [N_DIR-1:0] red,
  output logic [N_DIR-1:0] yellow,
  output logic [N_DIR-1:0] green,
  output logic [AW-1:0]    active,
  output logic [1:0]       phase
);

  localparam logic [1:0] PH_GREEN  = 2'd0;
  localparam logic [1:0] PH_YELLOW = 2'd1;
  localparam logic [1:0] PH_ALLRED = 2'd2;
  localparam logic [1:0] PH_FLASH  = 2'd3;

  // One counter serves every timed phase, so it must be wide enough for
  // the longest of them.
  localparam int CM1  = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
  localparam int CMAX = (CM1 > ALLRED_T) ? CM1 : ALLRED_T;
  localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;
  localparam int FW   = (FLASH_HALF > 1) ? $clog2(2 * FLASH_HALF) : 1;
  localparam int AW1  = AW + 1;

  localparam logic [CW-1:0] GMIN_M1    = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_M1    = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL_M1     = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] AR_M1      = CW'(ALLRED_T - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(2 * FLASH_HALF - 1);
  localparam logic [FW-1:0] FLASH_MID  = FW'(FLASH_HALF);

  logic [CW-1:0]    count;
  logic [FW-1:0]    flash_count;
  logic [AW-1:0]    next_dir;
  logic [AW-1:0]    next_sel;
  logic [AW:0]      cand_sum;
  logic [AW-1:0]    cand;
  logic             found;
  logic [N_DIR-1:0] active_oh;
  logic             pending;
  logic             go_yellow;

  assign active_oh = {{(N_DIR-1){1'b0}}, 1'b1} << active;
  assign pending   = |(sensor & ~active_oh);
  assign go_yellow = pending &&
                     (((count >= GMIN_M1) && !sensor[active]) || (count == GMAX_M1));

  // First waiting direction after active, in cyclic order. When pending is
  // true the scan always finds one; otherwise the result is unused.
  always_comb begin
    next_sel = active;
    found    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 1; k < N_DIR; k++) begin
      cand_sum = {1'b0, active} + AW1'(k);
      if (cand_sum >= AW1'(N_DIR)) cand_sum = cand_sum - AW1'(N_DIR);
      cand = cand_sum[AW-1:0];
      if (!found && sensor[cand]) begin
        found    = 1'b1;
        next_sel = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= PH_GREEN;
      active      <= '0;
      next_dir    <= '0;
      count       <= '0;
      flash_count <= '0;
    end else if (flash_en) begin
      phase <= PH_FLASH;
      count <= '0;
      // Restart the blink pattern on entry so the first half is always lit.
      if (phase != PH_FLASH || flash_count == FLASH_LAST) flash_count <= '0;
      else flash_count <= flash_count + FW'(1);
    end else begin
      case (phase)
        PH_GREEN: begin
          if (go_yellow) begin
            phase    <= PH_YELLOW;
            count    <= '0;
            next_dir <= next_sel;
          end else if (count != GMAX_M1) begin
            count <= count + CW'(1);
          end
        end
        PH_YELLOW: begin
          if (count == YEL_M1) begin
            phase <= PH_ALLRED;
            count <= '0;
          end else begin
            count <= count + CW'(1);
          end
        end
        PH_ALLRED: begin
          if (count == AR_M1) begin
            phase  <= PH_GREEN;
            count  <= '0;
            active <= next_dir;
          end else begin
            count <= count + CW'(1);
          end
        end
        PH_FLASH: begin
          // Leaving flash always restarts the rotation from direction 0.
          phase       <= PH_ALLRED;
          count       <= '0;
          active      <= '0;
          next_dir    <= '0;
          flash_count <= '0;
        end
      endcase
    end
  end

  always_comb begin
    red    = '0;
    yellow = '0;
    green  = '0;
    case (phase)
      PH_GREEN: begin
        green = active_oh;
        red   = ~active_oh;
      end
      PH_YELLOW: begin
        yellow = active_oh;
        red    = ~active_oh;
      end
      PH_ALLRED: red = '1;
      PH_FLASH:  yellow = (flash_count < FLASH_MID) ? '1 : '0;
    endcase
  end

endmodule

// File: doc/traffic_light_nway.md
TRAFFIC_LIGHT_NWAY -- requirements
Module: traffic_light_nway

Interface
REQ-001 Parameter N_DIR, default 4, is the number of approach directions, legal range 2..8.
REQ-002 Parameter GREEN_MIN, default 8, is the minimum green time in cycles, with GREEN_MIN >= 1.
REQ-003 Parameter GREEN_MAX, default 32, is the maximum green time in cycles while other directions wait, with GREEN_MAX >= GREEN_MIN.
REQ-004 Parameter YELLOW_T, default 3, is the yellow time in cycles, with YELLOW_T >= 1.
REQ-005 Parameter ALLRED_T, default 1, is the all-red clearance time in cycles, with ALLRED_T >= 1.
REQ-006 Parameter FLASH_HALF, default 4, is the half-period in cycles of the flashing-yellow mode, with FLASH_HALF >= 1.
REQ-007 Port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 Port sensor, input, N_DIR bits: bit j high means a vehicle is waiting on or occupying direction j.
REQ-010 Port flash_en, input, 1 bit: high requests flashing-yellow mode.
REQ-011 Port red, output, N_DIR bits: red lamp per direction.
REQ-012 Port yellow, output, N_DIR bits: yellow lamp per direction.
REQ-013 Port green, output, N_DIR bits: green lamp per direction.
REQ-014 Port active, output, max(1, clog2(N_DIR)) bits: index of the direction that owns the current phase.
REQ-015 Port phase, output, 2 bits: GREEN=0, YELLOW=1, ALLRED=2, FLASH=3.

Function
REQ-016 All outputs SHALL be decoded from registered state only (Moore) and have no combinational path from sensor or flash_en.
REQ-017 In every non-FLASH phase, exactly one lamp per direction SHALL be lit.
- GREEN: green[active]=1 and red=1 on all other directions.
- YELLOW: yellow[active]=1 and red=1 on all other directions.
- ALLRED: red=all ones; yellow and green all zero.
REQ-018 The phase counter SHALL be cleared on every phase entry and SHALL increment once per cycle, saturating at GREEN_MAX-1.
REQ-019 "pending" SHALL mean that some sensor[j] is high with j != active.
REQ-020 GREEN SHALL transition to YELLOW when pending is true and either of the following holds:
- counter >= GREEN_MIN-1 and sensor[active] is low; or
- counter == GREEN_MAX-1.
REQ-021 With no pending request, GREEN SHALL hold indefinitely, regardless of counter value.
REQ-022 On the GREEN->YELLOW transition, the next direction SHALL be latched as the first index after active, in cyclic order with wrap from N_DIR-1 to 0, whose sensor bit is high.
REQ-023 Sensor changes after the GREEN->YELLOW transition SHALL NOT alter the latched next direction.
REQ-024 YELLOW SHALL last exactly YELLOW_T cycles and then enter ALLRED.
REQ-025 ALLRED SHALL last exactly ALLRED_T cycles and then enter GREEN, with active set to the latched next direction.
REQ-026 flash_en high in any phase SHALL cause FLASH to be entered on the next edge, with priority over all transitions except rst.
REQ-027 In FLASH, red and green SHALL be all zeros.
REQ-028 In FLASH, yellow SHALL be all ones for the first FLASH_HALF cycles, then all zeros for FLASH_HALF cycles, repeating; sensors are ignored.
REQ-029 flash_en low while in FLASH SHALL cause ALLRED to be entered with active and next both forced to 0, followed by GREEN on direction 0.
REQ-030 Sensor changes mid-phase SHALL affect only GREEN-exit decisions and SHALL never shorten YELLOW or ALLRED.

Reset
REQ-031 rst high at a rising edge SHALL set the following, overriding all other inputs including flash_en:
- phase=GREEN, active=0, next=0, counter=0, flash counter=0;
- outputs green=...0001, red=...1110, yellow=0.
REQ-032 Reset SHALL take effect from any phase, including mid-YELLOW, mid-ALLRED and FLASH, in one cycle.

Verification (default parameters, cycle 0 = first cycle after rst release)
REQ-033 No sensors for 100 cycles -> green=0001, red=1110, yellow=0000 and phase=0 throughout.
REQ-034 sensor=0100 from cycle 0 -> GREEN on direction 0 during cycles 0-7, yellow[0] during cycles 8-10, red=1111 at cycle 11, green=0100 and active=2 at cycle 12.
REQ-035 sensor=0011 held -> green[0] during cycles 0-31, YELLOW during cycles 32-34, ALLRED at cycle 35, active=1 at cycle 36.
REQ-036 active=1 with sensor=1001 -> next selected is 3; then from 3 with sensor=0001 -> next wraps to 0.
REQ-037 flash_en asserted mid-YELLOW -> next cycle phase=3 with yellow=1111 for 4 cycles and then 0000 for 4 cycles; on flash_en deassert -> 1 cycle red=1111, then green=0001.
REQ-038 rst pulsed mid-ALLRED with flash_en=1 -> next cycle phase=0, active=0, green=0001.
